// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pkg
// Description : Shared LED output-stage constants (channel count, PWM width,
//               default timing and the resulting PWM period length).
// Revision    : 1.0 - initial release
// ============================================================================
package led_pkg;

    localparam int c_n_leds                 = 16;
    localparam int c_pwm_bits               = 8;
    localparam int c_prescale_dflt          = 390;
    localparam int c_fade_step_periods_dflt = 2;

    // clk100m cycles per PWM period; the pattern generator and power scripts
    // use this to line up with the fade rate.
    localparam int c_pwm_period_clks = c_prescale_dflt * (1 << c_pwm_bits);

endpackage
`default_nettype wire

// File: rtl/led_pwm_timebase.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm_timebase
// Description : Prescaler, PWM counter, period_start pulse and fade_step strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_timebase
    import led_pkg::*;
#(
    parameter int PWM_BITS          = c_pwm_bits,
    parameter int PRESCALE          = c_prescale_dflt,
    parameter int FADE_STEP_PERIODS = c_fade_step_periods_dflt
) (
    input  logic                clk100m,
    input  logic                rstn,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                period_start,
    output logic                fade_step
);

    localparam int c_pre_w  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_fade_w = (FADE_STEP_PERIODS > 1) ? $clog2(FADE_STEP_PERIODS) : 1;
    localparam logic [c_pre_w-1:0]  c_pre_last  = c_pre_w'(PRESCALE - 1);
    localparam logic [c_fade_w-1:0] c_fade_last = c_fade_w'(FADE_STEP_PERIODS - 1);

    logic [c_pre_w-1:0]  r_prescaler;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [c_fade_w-1:0] r_fade_cnt;
    logic                r_period_start;
    logic                w_tick;
    logic                w_wrap;
    logic                w_fade_wrap;

    assign w_tick      = (r_prescaler == c_pre_last);
    assign w_wrap      = w_tick && (r_pwm_cnt == '1);
    assign w_fade_wrap = (r_fade_cnt == c_fade_last);

    always_ff @(posedge clk100m or negedge rstn) begin
        if (!rstn) begin
            r_prescaler    <= '0;
            r_pwm_cnt      <= '0;
            r_fade_cnt     <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_prescaler    <= w_tick ? '0 : r_prescaler + 1'b1;
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            end
            // High during the first cycle of the period, where pwm_cnt is 0.
            r_period_start <= w_wrap;
            if (r_period_start) begin
                r_fade_cnt <= w_fade_wrap ? '0 : r_fade_cnt + 1'b1;
            end
        end
    end

    assign pwm_cnt      = r_pwm_cnt;
    assign period_start = r_period_start;
    assign fade_step    = r_period_start && w_fade_wrap;

endmodule
`default_nettype wire

// File: rtl/led_pwm_fader.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm_fader
// Description : Per-LED PWM drive with linear fading toward the requested level.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pwm_fader
    import led_pkg::*;
#(
    parameter int N_LEDS            = c_n_leds,
    parameter int PWM_BITS          = c_pwm_bits,
    parameter int PRESCALE          = c_prescale_dflt,
    parameter int FADE_STEP_PERIODS = c_fade_step_periods_dflt
) (
    input  logic                clk100m,
    input  logic                rstn,
    input  logic [N_LEDS-1:0]   pattern_in,
    input  logic                pattern_valid,
    input  logic [PWM_BITS-1:0] level_max,
    input  logic                enable,
    output logic [N_LEDS-1:0]   leds_out,
    output logic                busy,
    output logic                period_start
);

    logic [PWM_BITS-1:0] w_pwm_cnt;
    logic                w_period_start;
    logic                w_fade_step;
    logic [N_LEDS-1:0]   r_target;
    logic [PWM_BITS-1:0] r_level_lat;
    logic [N_LEDS-1:0]   w_diff;
    logic [N_LEDS-1:0]   w_led_on;
    logic [N_LEDS-1:0]   r_leds;
    logic                r_busy;

    led_pwm_timebase #(
        .PWM_BITS          (PWM_BITS),
        .PRESCALE          (PRESCALE),
        .FADE_STEP_PERIODS (FADE_STEP_PERIODS)
    ) u_timebase (
        .clk100m      (clk100m),
        .rstn         (rstn),
        .pwm_cnt      (w_pwm_cnt),
        .period_start (w_period_start),
        .fade_step    (w_fade_step)
    );

    // level_lat only moves at a period boundary so a mid-period level_max
    // change cannot truncate or stretch a pulse.
    always_ff @(posedge clk100m or negedge rstn) begin
        if (!rstn) begin
            r_target    <= '0;
            r_level_lat <= '0;
            r_leds      <= '0;
            r_busy      <= 1'b0;
        end else begin
            if (pattern_valid) begin
                r_target <= pattern_in;
            end
            if (w_period_start) begin
                r_level_lat <= level_max;
            end
            r_leds <= enable ? w_led_on : '0;
            r_busy <= |w_diff;
        end
    end

    generate
        for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_chan
            logic [PWM_BITS-1:0] r_level;
            logic [PWM_BITS-1:0] w_goal;

            assign w_goal = r_target[gi] ? r_level_lat : '0;

            always_ff @(posedge clk100m or negedge rstn) begin
                if (!rstn) begin
                    r_level <= '0;
                end else if (w_fade_step) begin
                    if (r_level < w_goal) begin
                        r_level <= r_level + 1'b1;
                    end else if (r_level > w_goal) begin
                        r_level <= r_level - 1'b1;
                    end
                end
            end

            assign w_diff[gi]   = (r_level != w_goal);
            assign w_led_on[gi] = (r_level > w_pwm_cnt);
        end
    endgenerate

    assign leds_out     = r_leds;
    assign busy         = r_busy;
    assign period_start = w_period_start;

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_fader.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_pwm_fader
// Description : Scoreboard bench: per-period duty and busy expectations from a
//               level-per-period model, checked by a free-running monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_pwm_fader;

    localparam int NL  = 16;
    localparam int PB  = 4;
    localparam int PS  = 2;
    localparam int FSP = 1;
    localparam int PER = PS * (1 << PB);

    logic          clk100m = 1'b0;
    logic          rstn = 1'b0;
    logic [NL-1:0] pattern_in = '0;
    logic          pattern_valid = 1'b0;
    logic [PB-1:0] level_max = 4'd15;
    logic          enable = 1'b1;
    logic [NL-1:0] leds_out;
    logic          busy;
    logic          period_start;

    always #5 clk100m = ~clk100m;

    led_pwm_fader #(
        .N_LEDS            (NL),
        .PWM_BITS          (PB),
        .PRESCALE          (PS),
        .FADE_STEP_PERIODS (FSP)
    ) dut (
        .clk100m       (clk100m),
        .rstn          (rstn),
        .pattern_in    (pattern_in),
        .pattern_valid (pattern_valid),
        .level_max     (level_max),
        .enable        (enable),
        .leds_out      (leds_out),
        .busy          (busy),
        .period_start  (period_start)
    );

    // en_mode: 1 = enabled for the whole window, 0 = disabled throughout, 2 = mixed
    typedef struct packed {
        logic [NL-1:0][PB-1:0] lev;
        logic [1:0]            en_mode;
        logic                  busy;
    } rec_t;

    rec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (one level value per channel per period)
    int            m_lev[NL];
    logic [NL-1:0] m_target = '0;
    int            m_lat = 0;
    int            en_low_left = 0;

    task automatic tick_enable();
        if (en_low_left > 0) begin
            en_low_left--;
            if (en_low_left == 0) enable = 1'b1;
        end
    endtask

    // Entered just after the edge that starts a period; leaves at the next one.
    task automatic run_period(input bit pv, input logic [NL-1:0] pat, input int lm,
                              input bit en_drop);
        rec_t r;
        bit   seen_hi;
        bit   seen_lo;
        bit   any_diff;
        for (int i = 0; i < NL; i++) begin
            int goal;
            goal = m_target[i] ? m_lat : 0;
            if (m_lev[i] < goal) m_lev[i]++;
            else if (m_lev[i] > goal) m_lev[i]--;
        end
        m_lat = int'(level_max);
        any_diff = 1'b0;
        for (int i = 0; i < NL; i++) begin
            if (m_lev[i] != (m_target[i] ? m_lat : 0)) any_diff = 1'b1;
        end
        tick_enable();
        seen_hi = 1'b0;
        seen_lo = 1'b0;
        for (int j = 1; j < PER; j++) begin
            @(posedge clk100m); #1;
            tick_enable();
            if (j == 24) begin
                level_max = lm[PB-1:0];
                if (pv) begin
                    pattern_in    = pat;
                    pattern_valid = 1'b1;
                    m_target      = pat;
                end
                if (en_drop) begin
                    enable      = 1'b0;
                    en_low_left = 50;
                end
            end else if (j == 25) begin
                pattern_valid = 1'b0;
            end
            if (enable) seen_hi = 1'b1;
            else        seen_lo = 1'b1;
            if (j == PER - 1) begin
                for (int i = 0; i < NL; i++) r.lev[i] = m_lev[i][PB-1:0];
                r.en_mode = (seen_hi && !seen_lo) ? 2'd1 : ((seen_lo && !seen_hi) ? 2'd0 : 2'd2);
                r.busy    = any_diff;
                exp_q.push_back(r);
            end
        end
        @(posedge clk100m); #1;
    endtask

    // ---------------- monitor: a window starts two cycles after period_start
    logic d0 = 1'b0, d1 = 1'b0, d2 = 1'b0;
    bit   win_active = 1'b0;
    int   acc[NL];
    int   phase = 0;
    logic busy_hold = 1'b0;
    logic prev_en = 1'b1;

    task automatic finalize();
        rec_t r;
        if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 1, 0);
        end else begin
            r = exp_q.pop_front();
            if (r.en_mode != 2'd2) begin
                for (int i = 0; i < NL; i++) begin
                    check($sformatf("duty_led%0d", i), acc[i],
                          (r.en_mode == 2'd1) ? 2 * int'(r.lev[i]) : 0);
                end
            end
            check("busy_mid_period", int'(busy_hold), int'(r.busy));
        end
    endtask

    always @(negedge clk100m) begin
        if (!rstn) begin
            d0 = 1'b0; d1 = 1'b0; d2 = 1'b0;
            win_active = 1'b0;
            phase = 0;
            prev_en = 1'b1;
        end else begin
            d2 = d1; d1 = d0; d0 = period_start;
            if (d2) begin
                if (win_active) finalize();
                win_active = 1'b1;
                for (int i = 0; i < NL; i++) acc[i] = 0;
            end
            if (win_active) begin
                for (int i = 0; i < NL; i++) acc[i] += int'(leds_out[i]);
            end
            if (period_start) phase = 0;
            else phase++;
            if (phase == 20) busy_hold = busy;
            if (!prev_en) check("leds_dark_when_disabled", int'(leds_out), 0);
            prev_en = enable;
        end
    end

    // ---------------- stimulus
    initial begin
        int  n;
        bit  found;
        for (int i = 0; i < NL; i++) m_lev[i] = 0;
        @(posedge clk100m); #1;
        check("reset_leds", int'(leds_out), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_period_start", int'(period_start), 0);
        @(posedge clk100m); #1;
        rstn = 1'b1;
        repeat (PER) @(posedge clk100m);
        #1;
        check("first_period_start", int'(period_start), 1);

        // fade up, reverse at level 7 back to 0
        run_period(1, 16'h0001, 15, 0);
        repeat (6) run_period(0, '0, 15, 0);
        run_period(1, 16'h0000, 15, 0);
        repeat (9) run_period(0, '0, 15, 0);

        // full fade up to 15 with an enable drop part way through
        run_period(1, 16'h0001, 15, 0);
        repeat (4) run_period(0, '0, 15, 0);
        run_period(0, '0, 15, 1);
        repeat (12) run_period(0, '0, 15, 0);

        // all channels to 15, then reduce level_max to 3 mid-period
        run_period(1, 16'hFFFF, 15, 0);
        repeat (16) run_period(0, '0, 15, 0);
        run_period(0, '0, 3, 0);
        repeat (14) run_period(0, '0, 3, 0);

        // steady level 4 on all channels
        run_period(0, '0, 4, 0);
        repeat (4) run_period(0, '0, 4, 0);

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            run_period($urandom_range(0, 2) == 0, NL'($urandom),
                       int'($urandom_range(0, 15)), $urandom_range(0, 9) == 0);
        end

        run_period(1, 16'h0000, 15, 0);
        repeat (8) run_period(0, '0, 15, 0);
        run_period(1, 16'hFFFF, 15, 0);
        repeat (2) run_period(0, '0, 15, 0);

        // asynchronous reset between edges, while fading
        repeat (4) @(posedge clk100m);
        check("busy_before_reset", int'(busy), 1);
        #3;
        rstn = 1'b0;
        #1;
        check("async_rst_leds", int'(leds_out), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_period_start", int'(period_start), 0);
        exp_q.delete();
        @(posedge clk100m); #1;
        rstn = 1'b1;
        n = 0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge clk100m);
            n++;
            #1;
            if (period_start) found = 1'b1;
        end
        check("period_start_after_reset", found ? n : -1, PER);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_pwm_fader.md
Name: led_pwm_fader

Overview:
- Output stage between the LED pattern generator and the board LED pins.
- Consumes a 16-bit on/off pattern and drives each LED with PWM at a programmable brightness.
- Each LED fades linearly toward its target level instead of switching hard, so power draw ramps gradually and is measurable.

Parameters:
N_LEDS, 16, number of LED channels
PWM_BITS, 8, PWM counter and brightness level width
PRESCALE, 390, clk100m cycles per PWM count step (390*256 cycles ~ 1 kHz PWM at 100 MHz); must be >= 1
FADE_STEP_PERIODS, 2, PWM periods per 1-LSB brightness step; must be >= 1

Ports:
clk100m  in  1  system clock, 100 MHz
rstn  in  1  reset, asynchronous, active-low
pattern_in  in  N_LEDS  requested on/off pattern, bit i = LED i
pattern_valid  in  1  one-cycle strobe; captures pattern_in
level_max  in  PWM_BITS  brightness of an "on" LED
enable  in  1  output enable; 0 forces all LEDs dark
leds_out  out  N_LEDS  PWM-modulated LED drive, registered
busy  out  1  1 while any channel level differs from its goal, registered
period_start  out  1  one-cycle pulse at the start of each PWM period

Behaviour:
- Reset: rstn low clears everything asynchronously. Cleared state:
  - prescaler, pwm_cnt, fade counter, target, level_lat, all level[i] = 0
  - leds_out = 0, busy = 0, period_start = 0
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick = (prescaler == PRESCALE-1).
- pwm_cnt (PWM_BITS wide):
  - Increments on tick.
  - Wraps 2^PWM_BITS-1 -> 0.
  - period_start is registered high for one cycle on the tick that wraps pwm_cnt to 0.
- level_lat:
  - Samples level_max only on the period_start cycle.
  - Mid-period level_max changes never glitch the waveform.
- Fade counter:
  - Counts period_start pulses 0..FADE_STEP_PERIODS-1.
  - fade_step is asserted on the period_start that wraps it.
- Target:
  - target <= pattern_in on the cycle pattern_valid is high.
  - A strobe mid-fade redirects the fade from the current level; levels never jump.
- Per channel goal[i] = target[i] ? level_lat : 0.
- Each fade_step, per channel:
  - level[i] < goal[i]: level[i] + 1.
  - level[i] > goal[i]: level[i] - 1.
  - Otherwise hold.
  - Step is exactly 1; no overflow or underflow is possible.
- Reducing level_max fades "on" LEDs down to the new value at the same rate.
- leds_out[i] <= enable && (level[i] > pwm_cnt):
  - Duty is level/2^PWM_BITS.
  - level 0 = always off.
  - Max level 2^PWM_BITS-1 = on for all but one count.
- enable = 0:
  - leds_out = 0 from the next cycle.
  - Counters and fades keep running; re-enable resumes at the current level.
- busy <= OR over i of (level[i] != goal[i]), evaluated every cycle.
- Latency:
  - pattern_valid to first level change: next fade_step.
  - level change to leds_out change: 1 cycle.
- pattern_valid and fade_step in the same cycle: the step uses the old target; the new target applies from the next fade_step.

Decomposition:
- Package led_pkg holds:
  - constants N_LEDS = 16, PWM_BITS = 8
  - default PRESCALE / FADE_STEP_PERIODS
  - PWM period length constant shared with the pattern generator and power scripts
- Sub-module led_pwm_timebase holds the prescaler, pwm_cnt, fade counter, period_start and fade_step generation.
- The top of led_pwm_fader keeps target, level_lat, level array, comparators and busy.

Test Plan:
Bench params: PRESCALE=2, PWM_BITS=4, FADE_STEP_PERIODS=1, so a PWM period is 32 clocks.
1. Assert rstn low asynchronously mid-run, between clock edges -> leds_out=0, busy=0, period_start=0 before the next clock edge; after release the first period_start appears 32 clocks later.
2. level_max=15, pattern_in=0x0001 with a pattern_valid pulse -> busy=1 from the next cycle; level[0] rises 1 per period, reaches 15 after 15 period_starts; busy=0; leds_out[0] high 30 of every 32 clocks; other bits stay 0.
3. Steady level_max=4, pattern 0xFFFF, fade complete -> every leds_out bit high exactly 8 consecutive clocks per 32-clock period, all bits in phase.
4. Pattern 0x0001 fading up; at level[0]=7 pulse pattern_valid with 0x0000 -> level[0] goes 7,6,...,0 on successive fade_steps, no jump; busy drops after the 7th step.
5. Mid-fade, drop enable for 50 clocks -> leds_out=0 from the cycle after enable falls; level keeps advancing; duty on re-enable matches the advanced level.
6. Full brightness at 15; change level_max 15->3 mid-period -> no waveform change until the next period_start; then level steps 15->3 over 12 periods; final duty is 6 of 32 clocks.
